// File: rtl/apb_gpio_param.sv
// APB GPIO block: NUM_PINS pins with direction, set/clear, synchronised inputs,
// per-pin rise/fall edge capture into a W1C status register and a level interrupt.
module apb_gpio_param #(
    parameter int NUM_PINS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [7:0]          PADDR,
    input  logic [31:0]         PWDATA,
    input  logic [3:0]          PSTRB,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    // state  | meaning
    // IDLE   | no transfer in progress
    // SETUP  | setup phase sampled; this cycle is the first access cycle
    // ACCESS | later access cycles (wait states / completion)
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [5:0] A_DOUT = 6'd0, A_DIR = 6'd1, A_DIN = 6'd2, A_IEN = 6'd3,
                           A_RISE = 6'd4, A_FALL = 6'd5, A_STAT = 6'd6, A_SET = 6'd7,
                           A_CLR = 6'd8;

    state_t              state;
    logic [1:0]          wait_cnt;
    logic [NUM_PINS-1:0] dout, dir, ien, rise, fall, stat;
    logic [NUM_PINS-1:0] sync1, din, din_prev;

    logic [5:0]          word;
    logic                setup_ph, access_ph, counting, load_rsp, err, do_write;
    logic [31:0]         rd_data, bmask;
    logic [NUM_PINS-1:0] wm, wbits, stat_set, stat_clr;
    logic                unused_bits;

    assign word      = PADDR[7:2];
    assign setup_ph  = PSEL && !PENABLE;
    assign access_ph = PSEL && PENABLE;
    assign counting  = (state != IDLE) && access_ph && !PREADY;
    assign load_rsp  = counting ? (wait_cnt == 2'd1) : (setup_ph && (WAIT_STATES == 0));
    assign do_write  = (state != IDLE) && PREADY && access_ph && PWRITE && !err;

    assign bmask       = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign wm          = bmask[NUM_PINS-1:0];
    assign wbits       = PWDATA[NUM_PINS-1:0] & wm;
    assign unused_bits = ^{PWDATA, bmask};

    assign stat_set = (din & ~din_prev & rise) | (~din & din_prev & fall);
    assign stat_clr = (do_write && word == A_STAT) ? wbits : '0;

    assign gpio_out = dout;
    assign gpio_oe  = dir;

    always_comb begin
        err = 1'b0;
        if (PADDR[1:0] != 2'b00 || word > A_CLR)
            err = 1'b1;
        else if (PWRITE && word == A_DIN)
            err = 1'b1;
        else if (!PWRITE && (word == A_SET || word == A_CLR || PSTRB != 4'h0))
            err = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        case (word)
            A_DOUT:  rd_data = 32'(dout);
            A_DIR:   rd_data = 32'(dir);
            A_DIN:   rd_data = 32'(din);
            A_IEN:   rd_data = 32'(ien);
            A_RISE:  rd_data = 32'(rise);
            A_FALL:  rd_data = 32'(fall);
            A_STAT:  rd_data = 32'(stat);
            default: rd_data = '0;
        endcase
    end

    // Response is registered one edge ahead so it is presented in the completion cycle.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            if (counting) begin
                state    <= ACCESS;
                wait_cnt <= wait_cnt - 2'd1;
            end else if (setup_ph) begin
                state    <= SETUP;
                wait_cnt <= 2'(WAIT_STATES);
            end else begin
                state <= IDLE;
            end
            if (load_rsp) begin
                PREADY  <= 1'b1;
                PSLVERR <= err;
                PRDATA  <= (err || PWRITE) ? '0 : rd_data;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            dout     <= '0;
            dir      <= '0;
            ien      <= '0;
            rise     <= '0;
            fall     <= '0;
            stat     <= '0;
            sync1    <= '0;
            din      <= '0;
            din_prev <= '0;
            irq      <= 1'b0;
        end else begin
            sync1    <= gpio_in;
            din      <= sync1;
            din_prev <= din;
            if (do_write) begin
                case (word)
                    A_DOUT:  dout <= (dout & ~wm) | wbits;
                    A_DIR:   dir  <= (dir  & ~wm) | wbits;
                    A_IEN:   ien  <= (ien  & ~wm) | wbits;
                    A_RISE:  rise <= (rise & ~wm) | wbits;
                    A_FALL:  fall <= (fall & ~wm) | wbits;
                    A_SET:   dout <= dout | wbits;
                    A_CLR:   dout <= dout & ~wbits;
                    default: ;
                endcase
            end
            // a new edge event beats a coincident clear
            stat <= (stat & ~stat_clr) | stat_set;
            irq  <= |(stat & ien);
        end
    end

endmodule

// File: tb/tb_apb_gpio_param.sv
// Bench for apb_gpio_param: a zero-wait-state and a two-wait-state instance on a shared bus.
module tb_apb_gpio_param;

    logic        PCLK, PRESETn;
    logic        psel0, psel2, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [7:0]  gpio_in;

    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2, irq0, irq2;
    logic [7:0]  gout0, goe0, gout2, goe2;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;

    apb_gpio_param #(.NUM_PINS(8), .WAIT_STATES(0)) u0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .gpio_in(gpio_in), .gpio_out(gout0), .gpio_oe(goe0), .irq(irq0)
    );

    apb_gpio_param #(.NUM_PINS(8), .WAIT_STATES(2)) u2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata2), .PREADY(pready2),
        .PSLVERR(pslverr2), .gpio_in(gpio_in), .gpio_out(gout2), .gpio_oe(goe2), .irq(irq2)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Response monitors: pop an expectation whenever PREADY is presented.
    always @(negedge PCLK) begin : mon0
        rsp_t e;
        n_vec++;
        if (pready0) begin
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL u0 unexpected completion: data 0x%08h err %0b", prdata0, pslverr0);
            end else begin
                e = q0.pop_front();
                if (prdata0 !== e.data || pslverr0 !== e.err) begin
                    n_err++;
                    $display("FAIL u0 response: got 0x%08h/%0b expected 0x%08h/%0b",
                             prdata0, pslverr0, e.data, e.err);
                end
            end
        end else if (prdata0 !== 32'h0 || pslverr0 !== 1'b0) begin
            n_err++;
            $display("FAIL u0 idle outputs: got 0x%08h/%0b expected 0/0", prdata0, pslverr0);
        end
    end

    always @(negedge PCLK) begin : mon2
        rsp_t e;
        n_vec++;
        if (pready2) begin
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL u2 unexpected completion: data 0x%08h err %0b", prdata2, pslverr2);
            end else begin
                e = q2.pop_front();
                if (prdata2 !== e.data || pslverr2 !== e.err) begin
                    n_err++;
                    $display("FAIL u2 response: got 0x%08h/%0b expected 0x%08h/%0b",
                             prdata2, pslverr2, e.data, e.err);
                end
            end
        end else if (prdata2 !== 32'h0 || pslverr2 !== 1'b0) begin
            n_err++;
            $display("FAIL u2 idle outputs: got 0x%08h/%0b expected 0/0", prdata2, pslverr2);
        end
    end

    task automatic apb(input bit ws2, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input bit ee, input int ew);
        rsp_t r;
        int   w;
        bit   got;
        r.data = ed;
        r.err  = ee;
        if (ws2) q2.push_back(r); else q0.push_back(r);
        @(posedge PCLK); #1;
        psel0 = !ws2; psel2 = ws2; PENABLE = 1'b0;
        PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        w = 0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge PCLK);
            if (ws2 ? pready2 : pready0) got = 1'b1; else w++;
        end
        chk($sformatf("wait cycles addr 0x%02h", a), got ? w : 99, ew);
        if (!got) begin
            if (ws2) void'(q2.pop_back()); else void'(q0.pop_back());
        end
        @(posedge PCLK); #1;
        psel0 = 1'b0; psel2 = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic w0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input bit ee);
        apb(1'b0, 1'b1, a, d, s, 32'h0, ee, 0);
    endtask

    task automatic r0(input logic [7:0] a, input logic [3:0] s, input logic [31:0] ed, input bit ee);
        apb(1'b0, 1'b0, a, 32'h0, s, ed, ee, 0);
    endtask

    initial begin
        PRESETn = 1'b1;
        psel0 = 1'b0; psel2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h0; PWDATA = 32'h0; PSTRB = 4'h0; gpio_in = 8'h00;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset pready0", pready0, 0);
        chk("reset prdata0", prdata0, 0);
        chk("reset irq0", irq0, 0);
        chk("reset gpio_oe0", goe0, 0);
        chk("reset gpio_out0", gout0, 0);
        chk("reset gpio_oe2", goe2, 0);
        PRESETn = 1'b0;

        // direction, strobed data write, readback, byte-lane masking
        w0(8'h04, 32'hFF, 4'hF, 0);
        w0(8'h00, 32'hA5, 4'b0001, 0);
        chk("gpio_oe after DIR", goe0, 8'hFF);
        chk("gpio_out after DOUT", gout0, 8'hA5);
        r0(8'h00, 4'h0, 32'hA5, 0);
        w0(8'h00, 32'h12, 4'b0010, 0);
        r0(8'h00, 4'h0, 32'hA5, 0);
        w0(8'h00, 32'h00, 4'h0, 0);
        r0(8'h00, 4'h0, 32'hA5, 0);
        w0(8'h00, 32'hFFFF_FF5A, 4'hF, 0);
        r0(8'h00, 4'h0, 32'h5A, 0);

        // set / clear
        w0(8'h00, 32'hF0, 4'hF, 0);
        w0(8'h1C, 32'h0F, 4'hF, 0);
        w0(8'h20, 32'h81, 4'hF, 0);
        r0(8'h00, 4'h0, 32'h7E, 0);
        chk("gpio_out after SET/CLR", gout0, 8'h7E);

        // error responses leave state untouched
        r0(8'h1C, 4'h0, 32'h0, 1);
        r0(8'h20, 4'h0, 32'h0, 1);
        r0(8'h24, 4'h0, 32'h0, 1);
        r0(8'h02, 4'h0, 32'h0, 1);
        w0(8'h08, 32'hFF, 4'hF, 1);
        r0(8'h08, 4'b0001, 32'h0, 1);
        w0(8'h01, 32'h00, 4'hF, 1);
        r0(8'h00, 4'h0, 32'h7E, 0);

        // rising edge capture, irq latency, W1C
        w0(8'h10, 32'h01, 4'hF, 0);
        w0(8'h0C, 32'h01, 4'hF, 0);
        r0(8'h08, 4'h0, 32'h00, 0);
        gpio_in[0] = 1'b1;
        @(posedge PCLK);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("stat before 3rd edge", u0.stat, 8'h00);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("stat at 3rd edge", u0.stat, 8'h01);
        chk("irq at 3rd edge", irq0, 0);
        @(negedge PCLK);
        chk("irq one cycle later", irq0, 1);
        r0(8'h18, 4'h0, 32'h01, 0);
        r0(8'h08, 4'h0, 32'h01, 0);
        w0(8'h18, 32'h01, 4'hF, 0);
        chk("stat after W1C", u0.stat, 8'h00);
        chk("irq lags W1C", irq0, 1);
        @(posedge PCLK); #1;
        chk("irq after W1C", irq0, 0);

        // falling edge sets STAT, then W1C coincident with a new rising edge
        w0(8'h14, 32'h01, 4'hF, 0);
        gpio_in[0] = 1'b0;
        repeat (5) @(posedge PCLK);
        #1;
        chk("irq after fall", irq0, 1);
        r0(8'h18, 4'h0, 32'h01, 0);
        repeat (3) @(posedge PCLK);
        #1;
        gpio_in[0] = 1'b1;
        w0(8'h18, 32'h01, 4'hF, 0);
        chk("stat set wins over clear", u0.stat, 8'h01);
        r0(8'h18, 4'h0, 32'h01, 0);
        w0(8'h18, 32'h01, 4'hF, 0);
        r0(8'h18, 4'h0, 32'h00, 0);

        // wait states and abort on the second instance
        apb(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, 32'h01, 0, 2);
        @(posedge PCLK); #1;
        psel2 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h33; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("abort access1 pready", pready2, 0);
        @(posedge PCLK); #1;
        psel2 = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("abort dropped pready", pready2, 0);
        @(negedge PCLK);
        chk("abort no write", gout2, 8'h00);
        apb(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 32'h00, 0, 2);
        apb(1'b1, 1'b1, 8'h00, 32'h33, 4'hF, 32'h00, 0, 2);
        apb(1'b1, 1'b0, 8'h00, 32'h0, 4'h0, 32'h33, 0, 2);

        // reset pulse during the access cycle of a write
        @(posedge PCLK); #1;
        psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h55; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 PRESETn = 1'b1;
        #1 chk("reset mid-access pready", pready0, 0);
        @(posedge PCLK); #1;
        psel0 = 1'b0; PENABLE = 1'b0; PRESETn = 1'b0;
        chk("reset mid-access dout", gout0, 8'h00);
        chk("reset mid-access dir", goe0, 8'h00);
        w0(8'h24, 32'h11, 4'hF, 1);
        w0(8'h00, 32'h55, 4'hF, 0);
        r0(8'h00, 4'h0, 32'h55, 0);
        chk("gpio_out after reset", gout0, 8'h55);

        repeat (3) @(posedge PCLK);
        #1;
        chk("u0 scoreboard drained", q0.size(), 0);
        chk("u2 scoreboard drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_gpio_param.md
APB_GPIO_PARAM -- requirements
Module: apb_gpio_param

Interface
REQ-001 SHALL have parameter NUM_PINS, default 8, number of GPIO pins (legal 1..32).
REQ-002 SHALL have parameter WAIT_STATES, default 0, number of ACCESS cycles with PREADY low before completion (legal 0..3).
REQ-003 SHALL have port PCLK, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port PRESETn, input, 1, reset; asynchronous, active-high (PRESETn=1 resets).
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE, all input, 1 bit each, APB control.
REQ-006 SHALL have port PADDR, input, 8, byte address.
REQ-007 SHALL have ports PWDATA, input, 32, write data, and PSTRB, input, 4, write byte strobes.
REQ-008 SHALL have ports PRDATA, output, 32, read data; PREADY, output, 1, transfer complete; PSLVERR, output, 1, transfer error.
REQ-009 SHALL have port gpio_in, input, NUM_PINS, asynchronous pad inputs.
REQ-010 SHALL have ports gpio_out and gpio_oe, both output, NUM_PINS; gpio_oe bit 1 means the pin drives.
REQ-011 SHALL have port irq, output, 1, registered level interrupt.

Function
REQ-012 SHALL implement FSM IDLE -> SETUP (PSEL & !PENABLE) -> ACCESS (PSEL & PENABLE) -> IDLE on completion, or SETUP again if PSEL & !PENABLE in the completion cycle.
REQ-013 SHALL hold PREADY low for WAIT_STATES ACCESS cycles, then high for exactly 1 cycle (the completion cycle); PREADY SHALL be low in IDLE/SETUP, except when WAIT_STATES=0, where PREADY=1 in the first ACCESS cycle.
REQ-014 SHALL abort to IDLE with no register update and PREADY/PSLVERR low if PSEL drops in ACCESS before completion.
REQ-015 SHALL update registers, drive PRDATA, and drive PSLVERR only in the completion cycle; PSLVERR=0 and PRDATA=0 in all other cycles.
REQ-016 SHALL decode word registers: 0x00 DOUT RW, 0x04 DIR RW, 0x08 DIN RO, 0x0C IEN RW, 0x10 RISE RW, 0x14 FALL RW, 0x18 STAT RW1C, 0x1C SET WO, 0x20 CLR WO.
REQ-017 SHALL respond to the following with PSLVERR=1, no state change, PRDATA=0: unmapped address, PADDR[1:0]!=0, write to DIN, read of SET/CLR, read with PSTRB!=0.
REQ-018 SHALL update, on writes, only byte lanes with PSTRB[n]=1; PSTRB=0 write completes without error and without change.
REQ-019 SHALL read bits [31:NUM_PINS] as 0 and ignore writes to them.
REQ-020 SHALL apply SET writes as DOUT |= masked data and CLR writes as DOUT &= ~masked data.
REQ-021 SHALL drive gpio_out=DOUT and gpio_oe=DIR directly from registers.
REQ-022 SHALL pass gpio_in through a 2-flop synchroniser; DIN=second stage; a 3rd flop holds DIN_prev.
REQ-023 SHALL set STAT[i] when (DIN[i]&!DIN_prev[i]&RISE[i]) | (!DIN[i]&DIN_prev[i]&FALL[i]); this applies regardless of DIR.
REQ-024 SHALL clear STAT bits written 1 via 0x18; a set event in the same cycle as a clear SHALL win (bit stays 1).
REQ-025 SHALL register irq = |(STAT & IEN), i.e. 1 cycle after STAT/IEN change.
REQ-026 SHALL make a pad edge visible in STAT 3 PCLK cycles after the input changes (synchroniser + edge flop), and in irq 1 cycle later.

Reset
REQ-027 SHALL, while PRESETn=1, immediately force FSM=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, irq=0, and all registers and synchroniser flops to 0 (gpio_oe=0: all pins input).
REQ-028 SHALL, on reset asserted mid-transfer, discard the transfer; the first transfer after release SHALL start from IDLE.

Verification
REQ-029 SHALL cover: NUM_PINS=8, write 0x04=0xFF, then 0x00=0xA5 with PSTRB=0001 -> gpio_oe=0xFF, gpio_out=0xA5, readback 0xA5, PSLVERR=0.
REQ-030 SHALL cover: DOUT=0xF0, write SET 0x0F then CLR 0x81 -> DOUT=0x7E; read 0x1C -> PSLVERR=1, PRDATA=0.
REQ-031 SHALL cover: RISE=0x01, IEN=0x01, gpio_in[0] 0->1 -> STAT=0x01 after 3 cycles, irq=1 one cycle later; write 0x18=0x01 -> STAT=0, irq=0 next cycle.
REQ-032 SHALL cover: W1C of STAT[0] coincident with a new rising edge on pin 0 -> STAT[0] remains 1.
REQ-033 SHALL cover: WAIT_STATES=2, read 0x08 -> PREADY low 2 ACCESS cycles, high on 3rd with DIN value; PSEL dropped in 2nd ACCESS cycle -> no completion, FSM IDLE.
REQ-034 SHALL cover: PRESETn pulsed during ACCESS of write 0x00=0x55 -> DOUT=0, PREADY=0; write PADDR=0x24 -> PSLVERR=1.
